// File: rtl/vga_layer_compositor.sv
// Fixed-priority VGA layer compositor: per-frame shadowed game state, external image ROMs
// with parametric latency, player damage blink and game-over fade-in.
module vga_layer_compositor #(
    parameter int unsigned N_OBS          = 10,
    parameter int unsigned N_TRAIL        = 41,
    parameter int unsigned MAX_HEART      = 5,
    parameter int unsigned ROM_LAT        = 1,
    parameter int unsigned BLINK_FRAMES   = 60,
    parameter int unsigned PLAYER_X       = 160,
    parameter int unsigned PLAYER_SIZE    = 40,
    parameter int unsigned GO_X           = 220,
    parameter int unsigned GO_Y           = 140,
    parameter int unsigned GO_SIZE        = 200,
    parameter int unsigned UPPER_BOUND    = 20,
    parameter int unsigned LOWER_BOUND    = 460,
    parameter int unsigned HEART_X        = 0,
    parameter int unsigned HEART_Y        = 463,
    parameter int unsigned HEART_SIZE     = 16,
    parameter int unsigned TRAIL_SIZE     = 4,
    parameter logic [11:0] COLOR_OBSTACLE = 12'hFA0,
    parameter logic [11:0] COLOR_PAUSED   = 12'hFF0,
    parameter logic [11:0] COLOR_ENDED    = 12'hFFF,
    parameter logic [11:0] COLOR_BORDER   = 12'h000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             pix_x,
    input  logic [8:0]             pix_y,
    input  logic                   pix_valid,
    input  logic                   frame_start,
    input  logic [1:0]             gamemode,
    input  logic [8:0]             player_y,
    input  logic [2:0]             heart,
    input  logic                   hit_pulse,
    input  logic [N_OBS*10-1:0]    obs_left,
    input  logic [N_OBS*10-1:0]    obs_right,
    input  logic [N_OBS*9-1:0]     obs_up,
    input  logic [N_OBS*9-1:0]     obs_down,
    input  logic [N_TRAIL*10-1:0]  trail_x,
    input  logic [N_TRAIL*9-1:0]   trail_y,
    input  logic [N_TRAIL*4-1:0]   trail_life,
    output logic [18:0]            addr_start,
    output logic [18:0]            addr_bg,
    output logic [10:0]            addr_player,
    output logic [15:0]            addr_over,
    output logic [7:0]             addr_heart,
    input  logic [11:0]            data_start,
    input  logic [11:0]            data_bg,
    input  logic [11:0]            data_player,
    input  logic [11:0]            data_over,
    input  logic [11:0]            data_heart,
    output logic [11:0]            rgb,
    output logic                   rgb_valid
);
    localparam int unsigned XW   = 10;
    localparam int unsigned YW   = 9;
    localparam int unsigned AW   = 11;
    localparam int unsigned HALF = TRAIL_SIZE / 2;
    localparam int unsigned BW   = ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);
    localparam logic [1:0] MODE_START = 2'b00;
    localparam logic [1:0] MODE_PLAY  = 2'b01;
    localparam logic [1:0] MODE_PAUSE = 2'b10;
    localparam logic [1:0] MODE_OVER  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [1:0]  mode;
        logic        heart;
        logic        border;
        logic        player;
        logic        obs;
        logic        trail;
        logic [11:0] trail_rgb;
        logic        over;
    } stage_t;

    function automatic logic [11:0] trail_color(input logic [3:0] life);
        case (life)
            4'd0:    return 12'h000;
            4'd1:    return 12'h669;
            4'd2:    return 12'h77A;
            4'd3:    return 12'h88B;
            4'd4:    return 12'h99C;
            4'd5:    return 12'hAAD;
            4'd6:    return 12'hBBE;
            4'd7:    return 12'hCCF;
            4'd8:    return 12'hDDF;
            4'd9:    return 12'hEEF;
            default: return 12'hFDD;
        endcase
    endfunction

    function automatic logic [3:0] fade_ch(input logic [3:0] ch, input logic [3:0] f);
        logic [7:0] prod;
        prod = 8'(ch) * (8'(f) + 8'd1);
        return 4'(prod >> 4);
    endfunction

    logic [1:0]             mode_q, mode_d;
    logic [8:0]             py_q, py_d;
    logic [2:0]             heart_q, heart_d;
    logic [N_OBS*10-1:0]    obs_l_q, obs_l_d, obs_r_q, obs_r_d;
    logic [N_OBS*9-1:0]     obs_u_q, obs_u_d, obs_dn_q, obs_dn_d;
    logic [N_TRAIL*10-1:0]  tr_x_q, tr_x_d;
    logic [N_TRAIL*9-1:0]   tr_y_q, tr_y_d;
    logic [N_TRAIL*4-1:0]   tr_life_q, tr_life_d;
    logic [BW-1:0]          blink_q, blink_d;
    logic [3:0]             fade_q, fade_d;
    logic [18:0]            addr_start_q, addr_start_d, addr_bg_q, addr_bg_d;
    logic [10:0]            addr_player_q, addr_player_d;
    logic [15:0]            addr_over_q, addr_over_d;
    logic [7:0]             addr_heart_q, addr_heart_d;
    logic [11:0]            rgb_q, rgb_d;
    logic                   rgb_valid_q, rgb_valid_d;
    stage_t                 pipe_q [ROM_LAT+1];
    stage_t                 pipe_d [ROM_LAT+1];
    stage_t                 s1, s_out;
    logic [AW-1:0]          x, y, py, tx, ty;
    logic [3:0]             life;
    logic [11:0]            over_rgb, lower_rgb;
    logic                   player_blank;

    assign player_blank = (blink_q != '0) && blink_q[2];

    // Shadow state, blink and fade counters advance only at frame_start / hit_pulse
    always_comb begin
        mode_d    = mode_q;
        py_d      = py_q;
        heart_d   = heart_q;
        obs_l_d   = obs_l_q;
        obs_r_d   = obs_r_q;
        obs_u_d   = obs_u_q;
        obs_dn_d  = obs_dn_q;
        tr_x_d    = tr_x_q;
        tr_y_d    = tr_y_q;
        tr_life_d = tr_life_q;
        blink_d   = blink_q;
        fade_d    = fade_q;
        if (frame_start) begin
            mode_d    = gamemode;
            py_d      = player_y;
            heart_d   = heart;
            obs_l_d   = obs_left;
            obs_r_d   = obs_right;
            obs_u_d   = obs_up;
            obs_dn_d  = obs_down;
            tr_x_d    = trail_x;
            tr_y_d    = trail_y;
            tr_life_d = trail_life;
            if (blink_q != '0) blink_d = blink_q - BW'(1);
            if (gamemode == MODE_OVER) begin
                if (mode_q != MODE_OVER) fade_d = 4'd0;
                else if (fade_q != 4'hF) fade_d = fade_q + 4'd1;
            end
        end
        if (hit_pulse) blink_d = BW'(BLINK_FRAMES);
    end

    // Stage 1: layer hit flags and ROM addresses for the incoming pixel
    always_comb begin
        x             = AW'(pix_x);
        y             = AW'(pix_y);
        py            = AW'(py_q);
        tx            = '0;
        ty            = '0;
        life          = '0;
        s1            = '0;
        s1.valid      = pix_valid;
        s1.mode       = mode_q;
        s1.border     = (y <= AW'(UPPER_BOUND)) || (y >= AW'(LOWER_BOUND));
        addr_start_d  = '0;
        addr_bg_d     = '0;
        addr_player_d = '0;
        addr_over_d   = '0;
        addr_heart_d  = '0;
        if (x < AW'(640) && y < AW'(480))
            addr_start_d = 19'(y) * 19'd640 + 19'(x);
        if (x < AW'(640) && y >= AW'(UPPER_BOUND) && y < AW'(LOWER_BOUND))
            addr_bg_d = 19'(y - AW'(UPPER_BOUND)) * 19'd640 + 19'(x);
        if (x >= AW'(PLAYER_X) && x < AW'(PLAYER_X + PLAYER_SIZE) &&
            y >= py && y < py + AW'(PLAYER_SIZE)) begin
            addr_player_d = 11'((y - py) * AW'(PLAYER_SIZE) + (x - AW'(PLAYER_X)));
            s1.player     = !player_blank;
        end
        if (x >= AW'(GO_X) && x < AW'(GO_X + GO_SIZE) && y >= AW'(GO_Y) && y < AW'(GO_Y + GO_SIZE)) begin
            addr_over_d = 16'(19'(y - AW'(GO_Y)) * 19'(GO_SIZE) + 19'(x - AW'(GO_X)));
            s1.over     = 1'b1;
        end
        for (int unsigned h = 0; h < MAX_HEART; h++) begin
            if (h < 32'(heart_q) &&
                x >= AW'(HEART_X + h * HEART_SIZE) && x < AW'(HEART_X + (h + 1) * HEART_SIZE) &&
                y >= AW'(HEART_Y) && y < AW'(HEART_Y + HEART_SIZE)) begin
                s1.heart     = 1'b1;
                addr_heart_d = 8'((y - AW'(HEART_Y)) * AW'(HEART_SIZE) + (x - AW'(HEART_X + h * HEART_SIZE)));
            end
        end
        for (int unsigned i = 0; i < N_OBS; i++) begin
            if (x >= AW'(obs_l_q[i*XW +: XW]) && x < AW'(obs_r_q[i*XW +: XW]) &&
                y >= AW'(obs_u_q[i*YW +: YW]) && y < AW'(obs_dn_q[i*YW +: YW]))
                s1.obs = 1'b1;
        end
        // Offset the pixel rather than the centre so squares near column/row 0 don't wrap
        for (int unsigned i = 0; i < N_TRAIL; i++) begin
            life = tr_life_q[i*4 +: 4];
            tx   = AW'(tr_x_q[i*XW +: XW]);
            ty   = AW'(tr_y_q[i*YW +: YW]);
            if (!s1.trail && life != 4'd0 &&
                x + AW'(HALF) >= tx && x + AW'(HALF) < tx + AW'(TRAIL_SIZE) &&
                y + AW'(HALF) >= ty && y + AW'(HALF) < ty + AW'(TRAIL_SIZE)) begin
                s1.trail     = 1'b1;
                s1.trail_rgb = trail_color(life);
            end
        end
    end

    // Flag delay line keeps layer hits aligned with ROM data
    always_comb begin
        pipe_d[0] = s1;
        for (int unsigned i = 1; i <= ROM_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    assign s_out = pipe_q[ROM_LAT];

    always_comb begin
        over_rgb    = {fade_ch(data_over[11:8], fade_q), fade_ch(data_over[7:4], fade_q),
                       fade_ch(data_over[3:0], fade_q)};
        lower_rgb   = (s_out.mode == MODE_OVER) ? COLOR_ENDED : data_bg;
        if (s_out.trail)  lower_rgb = s_out.trail_rgb;
        if (s_out.obs)    lower_rgb = COLOR_OBSTACLE;
        if (s_out.player) lower_rgb = data_player;
        if (s_out.border) lower_rgb = COLOR_BORDER;
        rgb_valid_d = s_out.valid;
        rgb_d       = '0;
        if (s_out.valid) begin
            case (s_out.mode)
                MODE_START: rgb_d = data_start;
                MODE_PLAY:  rgb_d = s_out.heart ? data_heart : lower_rgb;
                MODE_PAUSE: rgb_d = s_out.heart ? data_heart : COLOR_PAUSED;
                default:    rgb_d = s_out.heart ? data_heart : (s_out.over ? over_rgb : lower_rgb);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= '0;
            py_q          <= '0;
            heart_q       <= '0;
            obs_l_q       <= '0;
            obs_r_q       <= '0;
            obs_u_q       <= '0;
            obs_dn_q      <= '0;
            tr_x_q        <= '0;
            tr_y_q        <= '0;
            tr_life_q     <= '0;
            blink_q       <= '0;
            fade_q        <= '0;
            addr_start_q  <= '0;
            addr_bg_q     <= '0;
            addr_player_q <= '0;
            addr_over_q   <= '0;
            addr_heart_q  <= '0;
            rgb_q         <= '0;
            rgb_valid_q   <= 1'b0;
            for (int unsigned i = 0; i <= ROM_LAT; i++) pipe_q[i] <= '0;
        end else begin
            mode_q        <= mode_d;
            py_q          <= py_d;
            heart_q       <= heart_d;
            obs_l_q       <= obs_l_d;
            obs_r_q       <= obs_r_d;
            obs_u_q       <= obs_u_d;
            obs_dn_q      <= obs_dn_d;
            tr_x_q        <= tr_x_d;
            tr_y_q        <= tr_y_d;
            tr_life_q     <= tr_life_d;
            blink_q       <= blink_d;
            fade_q        <= fade_d;
            addr_start_q  <= addr_start_d;
            addr_bg_q     <= addr_bg_d;
            addr_player_q <= addr_player_d;
            addr_over_q   <= addr_over_d;
            addr_heart_q  <= addr_heart_d;
            rgb_q         <= rgb_d;
            rgb_valid_q   <= rgb_valid_d;
            for (int unsigned i = 0; i <= ROM_LAT; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign addr_start  = addr_start_q;
    assign addr_bg     = addr_bg_q;
    assign addr_player = addr_player_q;
    assign addr_over   = addr_over_q;
    assign addr_heart  = addr_heart_q;
    assign rgb         = rgb_q;
    assign rgb_valid   = rgb_valid_q;
endmodule
